// File: rtl/hazard_detection_unit.sv
// rtl/hazard_detection_unit.sv - pipeline stall/flush controller with MUL/DIV occupancy and hazard counters
module hazard_detection_unit #(
    parameter int MULDIV_LAT = 4,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       ID_rs1,
    input  logic [4:0]       ID_rs2,
    input  logic             ID_use_rs1,
    input  logic             ID_use_rs2,
    input  logic             ID_EX_MemRead,
    input  logic [4:0]       ID_EX_rd,
    input  logic             ID_EX_MulDiv,
    input  logic             EX_branch_taken,
    output logic             PC_Write,
    output logic             IF_ID_Write,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Flush,
    output logic             EX_Hold,
    output logic             EX_MEM_Bubble,
    output logic             MulDiv_Done,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic {IDLE, MD_BUSY} state_t;

    localparam logic [3:0]       MD_INIT = 4'(MULDIV_LAT - 2);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    logic [3:0]       md_cnt_q, md_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             load_use;
    logic             stall_inc;
    logic             flush_inc;

    assign load_use = ID_EX_MemRead && (ID_EX_rd != 5'd0) &&
                      ((ID_use_rs1 && (ID_rs1 == ID_EX_rd)) ||
                       (ID_use_rs2 && (ID_rs2 == ID_EX_rd)));

    always_comb begin
        PC_Write      = 1'b1;
        IF_ID_Write   = 1'b1;
        IF_ID_Flush   = 1'b0;
        ID_EX_Flush   = 1'b0;
        EX_Hold       = 1'b0;
        EX_MEM_Bubble = 1'b0;
        MulDiv_Done   = 1'b0;
        state_d       = state_q;
        md_cnt_d      = md_cnt_q;
        stall_inc     = 1'b0;
        flush_inc     = 1'b0;

        if (rst) begin
            PC_Write    = 1'b0;
            IF_ID_Write = 1'b0;
            IF_ID_Flush = 1'b1;
            ID_EX_Flush = 1'b1;
            state_d     = IDLE;
            md_cnt_d    = 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (EX_branch_taken) begin
                        // ID holds a wrong-path instruction, so its load-use is moot
                        IF_ID_Flush = 1'b1;
                        ID_EX_Flush = 1'b1;
                        flush_inc   = 1'b1;
                    end else if (ID_EX_MulDiv) begin
                        EX_Hold       = 1'b1;
                        EX_MEM_Bubble = 1'b1;
                        PC_Write      = 1'b0;
                        IF_ID_Write   = 1'b0;
                        state_d       = MD_BUSY;
                        md_cnt_d      = MD_INIT;
                        stall_inc     = 1'b1;
                    end else if (load_use) begin
                        PC_Write    = 1'b0;
                        IF_ID_Write = 1'b0;
                        ID_EX_Flush = 1'b1;
                        stall_inc   = 1'b1;
                    end
                end
                MD_BUSY: begin
                    if (md_cnt_q != 4'd0) begin
                        EX_Hold       = 1'b1;
                        EX_MEM_Bubble = 1'b1;
                        PC_Write      = 1'b0;
                        IF_ID_Write   = 1'b0;
                        md_cnt_d      = md_cnt_q - 4'd1;
                        stall_inc     = 1'b1;
                    end else begin
                        MulDiv_Done = 1'b1;
                        state_d     = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (rst) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (stall_inc && (stall_cnt_q != CNT_MAX)) stall_cnt_d = stall_cnt_q + CNT_ONE;
            if (flush_inc && (flush_cnt_q != CNT_MAX)) flush_cnt_d = flush_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        state_q     <= state_d;
        md_cnt_q    <= md_cnt_d;
        stall_cnt_q <= stall_cnt_d;
        flush_cnt_q <= flush_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_detection_unit.sv
// tb/tb_hazard_detection_unit.sv - scoreboard bench for hazard_detection_unit
module tb_hazard_detection_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] ID_rs1 = '0, ID_rs2 = '0, ID_EX_rd = '0;
    logic       ID_use_rs1 = 1'b0, ID_use_rs2 = 1'b0;
    logic       ID_EX_MemRead = 1'b0, ID_EX_MulDiv = 1'b0, EX_branch_taken = 1'b0;

    logic        pc_w, ifid_w, ifid_f, idex_f, hold, bub, done;
    logic [31:0] stall_cnt, flush_cnt;
    logic        s_pc_w, s_ifid_w, s_ifid_f, s_idex_f, s_hold, s_bub, s_done;
    logic [3:0]  s_stall_cnt, s_flush_cnt;

    always #5 clk = ~clk;

    hazard_detection_unit #(.MULDIV_LAT(4), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .ID_rs1(ID_rs1), .ID_rs2(ID_rs2),
        .ID_use_rs1(ID_use_rs1), .ID_use_rs2(ID_use_rs2),
        .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_rd(ID_EX_rd),
        .ID_EX_MulDiv(ID_EX_MulDiv), .EX_branch_taken(EX_branch_taken),
        .PC_Write(pc_w), .IF_ID_Write(ifid_w), .IF_ID_Flush(ifid_f),
        .ID_EX_Flush(idex_f), .EX_Hold(hold), .EX_MEM_Bubble(bub),
        .MulDiv_Done(done), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    hazard_detection_unit #(.MULDIV_LAT(4), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .ID_rs1(ID_rs1), .ID_rs2(ID_rs2),
        .ID_use_rs1(ID_use_rs1), .ID_use_rs2(ID_use_rs2),
        .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_rd(ID_EX_rd),
        .ID_EX_MulDiv(ID_EX_MulDiv), .EX_branch_taken(EX_branch_taken),
        .PC_Write(s_pc_w), .IF_ID_Write(s_ifid_w), .IF_ID_Flush(s_ifid_f),
        .ID_EX_Flush(s_idex_f), .EX_Hold(s_hold), .EX_MEM_Bubble(s_bub),
        .MulDiv_Done(s_done), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    // {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, EX_Hold, EX_MEM_Bubble, MulDiv_Done}
    localparam logic [6:0] O_RST  = 7'b0011000;
    localparam logic [6:0] O_NORM = 7'b1100000;
    localparam logic [6:0] O_BR   = 7'b1111000;
    localparam logic [6:0] O_MD   = 7'b0000110;
    localparam logic [6:0] O_LU   = 7'b0001000;
    localparam logic [6:0] O_DONE = 7'b1100001;

    typedef struct {
        string       name;
        logic [6:0]  outs;
        logic [31:0] stall;
        logic [31:0] flush;
        logic [3:0]  sat_stall;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic step(input string name, input logic r, input logic br, input logic md,
                        input logic mr, input logic [4:0] rd,
                        input logic u1, input logic [4:0] rs1,
                        input logic u2, input logic [4:0] rs2,
                        input logic [6:0] outs, input int st, input int fl);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; EX_branch_taken = br; ID_EX_MulDiv = md;
        ID_EX_MemRead = mr; ID_EX_rd = rd;
        ID_use_rs1 = u1; ID_rs1 = rs1; ID_use_rs2 = u2; ID_rs2 = rs2;
        e.name = name; e.outs = outs; e.stall = 32'(st); e.flush = 32'(fl);
        e.sat_stall = (st > 15) ? 4'd15 : 4'(st);
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            logic [6:0] act, act_s;
            e = sb.pop_front();
            act   = {pc_w, ifid_w, ifid_f, idex_f, hold, bub, done};
            act_s = {s_pc_w, s_ifid_w, s_ifid_f, s_idex_f, s_hold, s_bub, s_done};
            n_cmp += 5;
            if (act !== e.outs) begin
                n_bad++;
                $display("FAIL %s outputs: got %b expected %b", e.name, act, e.outs);
            end
            if (act_s !== e.outs) begin
                n_bad++;
                $display("FAIL %s outputs_w4: got %b expected %b", e.name, act_s, e.outs);
            end
            if (stall_cnt !== e.stall) begin
                n_bad++;
                $display("FAIL %s stall_cnt: got %0d expected %0d", e.name, stall_cnt, e.stall);
            end
            if (flush_cnt !== e.flush) begin
                n_bad++;
                $display("FAIL %s flush_cnt: got %0d expected %0d", e.name, flush_cnt, e.flush);
            end
            if (s_stall_cnt !== e.sat_stall) begin
                n_bad++;
                $display("FAIL %s stall_cnt_w4: got %0d expected %0d", e.name, s_stall_cnt, e.sat_stall);
            end
        end
    end

    initial begin
        int budget;
        //   name          rst br md mr rd   u1 rs1  u2 rs2  outs    stall flush
        step("reset",      1, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, O_RST,  0, 0);
        step("lu_rs2",     0, 0, 0, 1, 5'd5, 1, 5'd1, 1, 5'd5, O_LU,   0, 0);
        step("after_lu",   0, 0, 0, 0, 5'd5, 1, 5'd1, 1, 5'd5, O_NORM, 1, 0);
        step("lu_rs1",     0, 0, 0, 1, 5'd9, 1, 5'd9, 1, 5'd3, O_LU,   1, 0);
        step("after_lu1",  0, 0, 0, 0, 5'd0, 1, 5'd9, 1, 5'd3, O_NORM, 2, 0);
        step("rd_x0",      0, 0, 0, 1, 5'd0, 1, 5'd0, 0, 5'd0, O_NORM, 2, 0);
        step("unused_rs2", 0, 0, 0, 1, 5'd7, 1, 5'd1, 0, 5'd7, O_NORM, 2, 0);
        step("unused_rs1", 0, 0, 0, 1, 5'd7, 0, 5'd7, 1, 5'd2, O_NORM, 2, 0);
        step("reset2",     1, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, O_RST,  2, 0);
        step("br_over_lu", 0, 1, 0, 1, 5'd5, 0, 5'd0, 1, 5'd5, O_BR,   0, 0);
        step("after_br",   0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, O_NORM, 0, 1);
        step("md_c0",      0, 0, 1, 0, 5'd0, 0, 5'd0, 0, 5'd0, O_MD,   0, 1);
        step("md_c1_br",   0, 1, 1, 1, 5'd5, 0, 5'd0, 1, 5'd5, O_MD,   1, 1);
        step("md_c2",      0, 0, 1, 0, 5'd0, 0, 5'd0, 0, 5'd0, O_MD,   2, 1);
        step("md_c3_done", 0, 0, 1, 1, 5'd5, 0, 5'd0, 1, 5'd5, O_DONE, 3, 1);
        step("after_md",   0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, O_NORM, 3, 1);
        step("b2b_c0",     0, 0, 1, 0, 5'd0, 0, 5'd0, 0, 5'd0, O_MD,   3, 1);
        step("b2b_c1",     0, 0, 1, 0, 5'd0, 0, 5'd0, 0, 5'd0, O_MD,   4, 1);
        step("b2b_c2",     0, 0, 1, 0, 5'd0, 0, 5'd0, 0, 5'd0, O_MD,   5, 1);
        step("b2b_c3",     0, 0, 1, 0, 5'd0, 0, 5'd0, 0, 5'd0, O_DONE, 6, 1);
        step("b2b_c4",     0, 0, 1, 0, 5'd0, 0, 5'd0, 0, 5'd0, O_MD,   6, 1);
        step("b2b_c5",     0, 0, 1, 0, 5'd0, 0, 5'd0, 0, 5'd0, O_MD,   7, 1);
        step("b2b_c6",     0, 0, 1, 0, 5'd0, 0, 5'd0, 0, 5'd0, O_MD,   8, 1);
        step("b2b_c7",     0, 0, 1, 0, 5'd0, 0, 5'd0, 0, 5'd0, O_DONE, 9, 1);
        step("b2b_end",    0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, O_NORM, 9, 1);
        step("rmd_c0",     0, 0, 1, 0, 5'd0, 0, 5'd0, 0, 5'd0, O_MD,   9, 1);
        step("rmd_rst",    1, 0, 1, 0, 5'd0, 0, 5'd0, 0, 5'd0, O_RST, 10, 1);
        step("rmd_idle",   0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, O_NORM, 0, 0);
        step("rmd_idle2",  0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, O_NORM, 0, 0);
        for (int i = 0; i < 20; i++)
            step("sat_lu",  0, 0, 0, 1, 5'd12, 1, 5'd12, 0, 5'd0, O_LU, i, 0);
        step("sat_end",    0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, O_NORM, 20, 0);
        step("sat_hold",   0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, O_NORM, 20, 0);

        budget = 0;
        while (sb.size() > 0 && budget < 20) begin
            @(posedge clk);
            budget++;
        end
        if (sb.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
